uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter MAX_PKT, default 16, maximum data bytes per granted packet (1..255).
REQ-003 SHALL have parameter HDR_EN, default 1, enables a one-byte requester-ID header per packet.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester byte valid.
REQ-007 SHALL have port req_data  input  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 SHALL have port req_last  input  NUM_REQ  per-requester end-of-packet flag, qualified by req_valid.
REQ-009 SHALL have port req_ready  output  NUM_REQ  per-requester byte accepted this cycle when ANDed with req_valid.
REQ-010 SHALL have port fifo_full  input  1  TX data FIFO full.
REQ-011 SHALL have port fifo_wr  output  1  single-cycle write strobe into TX data FIFO.
REQ-012 SHALL have port fifo_data  output  8  byte written when fifo_wr=1.
REQ-013 SHALL have port grant  output  NUM_REQ  one-hot current owner; all-zero when idle.
REQ-014 SHALL have port busy  output  1  high while any packet is owned.
REQ-015 SHALL have port trunc_err  output  1  one-cycle pulse when a packet is cut at MAX_PKT.

Function
REQ-016 SHALL implement FSM states IDLE, HEADER, DATA.
REQ-017 In IDLE with any req_valid set, SHALL select the first set requester searching upward (with wrap) from last_owner+1, register grant, and enter HEADER if HDR_EN=1, else DATA.
REQ-018 In IDLE with no req_valid, SHALL remain in IDLE with grant=0, busy=0.
REQ-019 In HEADER, SHALL drive fifo_wr=!fifo_full, fifo_data={4'hA, 4-bit owner index}, and move to DATA the cycle the write occurs.
REQ-020 In DATA, SHALL drive req_ready[owner]=!fifo_full, all other req_ready bits 0, and fifo_wr=req_valid[owner]&&!fifo_full, fifo_data=owner's req_data, combinationally.
REQ-021 SHALL never assert req_ready in IDLE or HEADER.
REQ-022 SHALL count accepted data bytes per packet (8-bit counter, cleared on grant).
REQ-023 On an accepted byte with req_last=1, SHALL return to IDLE next cycle and set last_owner=owner.
REQ-024 On the accepted byte that makes the count equal MAX_PKT with req_last=0, SHALL pulse trunc_err next cycle, return to IDLE, set last_owner=owner; the requester's remaining bytes form a new packet.
REQ-025 Accepted byte with req_last=1 reaching MAX_PKT SHALL end normally without trunc_err.
REQ-026 In DATA with req_valid[owner]=0, SHALL hold ownership indefinitely (no timeout, no preemption).
REQ-027 Changes of other requesters' req_valid during a packet SHALL have no effect until IDLE.
REQ-028 Minimum packet spacing SHALL be one IDLE cycle between last byte and next header/first byte.
REQ-029 busy SHALL equal (state!=IDLE); grant SHALL be registered and stable for the whole packet.

Reset
REQ-030 On rst=0, SHALL asynchronously set state=IDLE, grant=0, count=0, last_owner=NUM_REQ-1 (requester 0 highest priority first), trunc_err=0.
REQ-031 Reset mid-packet SHALL abandon the packet with no further fifo_wr; outputs busy, fifo_wr, req_ready SHALL read 0 while rst=0.

Structure
REQ-032 SHALL take the state enum and header tag constant (4'hA) from shared package uart_pkg.
REQ-033 SHALL instantiate one sub-module rr_pick: combinational round-robin picker (request vector, last_owner in; one-hot and index out).
REQ-034 Implementation SHALL be 120-400 lines of RTL total.

Verification
REQ-035 Single requester: req 2 sends 3 bytes 0x11,0x22,0x33(last), HDR_EN=1, fifo_full=0 -> fifo writes 0xA2,0x11,0x22,0x33 on consecutive cycles; busy drops after.
REQ-036 Round-robin: all 4 requesters continuously valid with 1-byte packets after reset -> grant order 0,1,2,3,0; headers 0xA0,0xA1,0xA2,0xA3.
REQ-037 Backpressure: fifo_full=1 for 5 cycles during DATA -> req_ready=0 and fifo_wr=0 those cycles; no byte lost or duplicated.
REQ-038 Truncation: MAX_PKT=4, requester 1 sends 6 bytes, last on 6th -> packet A1+4 bytes, trunc_err pulse, then (alone) A1+2 bytes.
REQ-039 Reset mid-packet: rst low after 2 of 5 bytes -> fifo_wr stops immediately; after release, requester 0 wins if valid alongside others.
REQ-040 Owner stall: req_valid[owner]=0 for 10 cycles while others valid -> grant unchanged, no fifo_wr until owner resumes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared state encoding and header constants for the UART TX byte-stream arbiter.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HEADER = 2'd1,
      ST_DATA   = 2'd2
   } arb_state_e;

   localparam logic [3:0] HDR_TAG = 4'hA;

   // Header byte: tag in the high nibble, owning requester index in the low nibble.
   function automatic logic [7:0] hdr_byte(input logic [3:0] owner_idx);
      return {HDR_TAG, owner_idx};
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward (with wrap)
// from the slot after i_last_owner.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last_owner,
   output logic               o_any,
   output logic [NUM_REQ-1:0] o_onehot,
   output logic [IDX_W-1:0]   o_idx
);

   int w_dist;
   int w_best_dist;

   // Rank each requester by its distance past last_owner; the smallest distance wins.
   always_comb begin
      o_any       = 1'b0;
      o_onehot    = '0;
      o_idx       = '0;
      w_dist      = 0;
      w_best_dist = NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (j > int'(i_last_owner)) begin
            w_dist = j - int'(i_last_owner) - 1;
         end else begin
            w_dist = j + NUM_REQ - int'(i_last_owner) - 1;
         end
         if (i_req[j] && (w_dist < w_best_dist)) begin
            w_best_dist = w_dist;
            o_any       = 1'b1;
            o_onehot    = '0;
            o_onehot[j] = 1'b1;
            o_idx       = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet arbiter: grants one byte-stream requester at a time, optionally prefixes a
// requester-ID header, and streams its bytes into the TX data FIFO.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int MAX_PKT = 16,
   parameter int HDR_EN  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic                 fifo_full,
   output logic                 fifo_wr,
   output logic [7:0]           fifo_data,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic                 trunc_err,
   output logic [1:0]           dbg_state
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Handshake: a requester byte moves when req_valid[i] && req_ready[i] at a rising
   // edge. req_ready never depends on req_valid; it is only the owner's bit, in DATA,
   // when the FIFO has room. fifo_wr is a one-cycle strobe qualified by !fifo_full.

   arb_state_e           r_state;
   arb_state_e           w_state_nxt;
   logic [NUM_REQ-1:0]   r_grant;
   logic [IDX_W-1:0]     r_owner;
   logic [IDX_W-1:0]     r_last_owner;
   logic [7:0]           r_count;
   logic                 r_trunc_err;

   logic                 w_any;
   logic [NUM_REQ-1:0]   w_pick_oh;
   logic [IDX_W-1:0]     w_pick_idx;
   logic                 w_own_valid;
   logic                 w_own_last;
   logic [7:0]           w_own_data;
   logic [7:0]           w_cnt_inc;
   logic                 w_accept;
   logic                 w_end_last;
   logic                 w_end_trunc;
   logic                 w_fifo_wr;
   logic [7:0]           w_fifo_data;
   logic [NUM_REQ-1:0]   w_ready;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .i_req        (req_valid),
      .i_last_owner (r_last_owner),
      .o_any        (w_any),
      .o_onehot     (w_pick_oh),
      .o_idx        (w_pick_idx)
   );

   // The registered one-hot grant doubles as the owner select for the byte mux.
   always_comb begin
      w_own_data = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         w_own_data = w_own_data | (req_data[j*8 +: 8] & {8{r_grant[j]}});
      end
   end

   assign w_own_valid = |(req_valid & r_grant);
   assign w_own_last  = |(req_last & r_grant);
   assign w_cnt_inc   = r_count + 8'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fifo_wr   = 1'b0;
      w_fifo_data = '0;
      w_ready     = '0;
      w_accept    = 1'b0;
      w_end_last  = 1'b0;
      w_end_trunc = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_nxt = (HDR_EN != 0) ? ST_HEADER : ST_DATA;
            end
         end
         ST_HEADER: begin
            w_fifo_wr   = !fifo_full;
            w_fifo_data = hdr_byte(4'(r_owner));
            if (!fifo_full) begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            w_ready     = r_grant & {NUM_REQ{!fifo_full}};
            w_accept    = w_own_valid && !fifo_full;
            w_fifo_wr   = w_accept;
            w_fifo_data = w_own_data;
            if (w_accept) begin
               // A last flag on the MAX_PKT-th byte is a clean end, not a truncation.
               if (w_own_last) begin
                  w_end_last = 1'b1;
               end else if (w_cnt_inc == 8'(MAX_PKT)) begin
                  w_end_trunc = 1'b1;
               end
            end
            if (w_end_last || w_end_trunc) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_grant      <= '0;
         r_owner      <= '0;
         r_last_owner <= IDX_W'(NUM_REQ - 1);
         r_count      <= '0;
         r_trunc_err  <= 1'b0;
      end else begin
         r_trunc_err <= w_end_trunc;
         if ((r_state == ST_IDLE) && w_any) begin
            r_grant <= w_pick_oh;
            r_owner <= w_pick_idx;
            r_count <= '0;
         end else if (w_accept) begin
            r_count <= w_cnt_inc;
         end
         if (w_end_last || w_end_trunc) begin
            r_grant      <= '0;
            r_last_owner <= r_owner;
         end
      end
   end

   assign req_ready = w_ready;
   assign fifo_wr   = w_fifo_wr;
   assign fifo_data = w_fifo_data;
   assign grant     = r_grant;
   assign busy      = (r_state != ST_IDLE);
   assign trunc_err = r_trunc_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scenarios with random payloads, checked against a packet-level model of
// round-robin arbitration, headers and MAX_PKT truncation.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int MAX_PKT = 4;
   localparam int HDR_EN  = 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*8-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 fifo_full;
   logic                 fifo_wr;
   logic [7:0]           fifo_data;
   logic [NUM_REQ-1:0]   grant;
   logic                 busy;
   logic                 trunc_err;
   logic [1:0]           dbg_state;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ (NUM_REQ),
      .MAX_PKT (MAX_PKT),
      .HDR_EN  (HDR_EN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .fifo_full (fifo_full),
      .fifo_wr   (fifo_wr),
      .fifo_data (fifo_data),
      .grant     (grant),
      .busy      (busy),
      .trunc_err (trunc_err),
      .dbg_state (dbg_state)
   );

   int                 n_assert = 0;
   int                 n_fail   = 0;
   logic [8:0]         src_q[NUM_REQ][$];
   logic [7:0]         exp_q[$];
   int                 exp_grant_q[$];
   int                 wr_cyc_q[$];
   int                 m_last_owner;
   int                 exp_trunc_total = 0;
   int                 seen_trunc = 0;
   int                 pkt_cnt;
   logic               trunc_pending;
   logic [NUM_REQ-1:0] prev_grant;
   logic [NUM_REQ-1:0] stall_mask;
   logic               full_force;
   logic               rst_drive;
   int                 cyc = 0;
   logic               saw_wr;
   logic [7:0]         saw_data;
   int                 saw_acc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit pending();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (src_q[i].size() > 0) return 1'b1;
      end
      return (exp_q.size() > 0);
   endfunction

   // Packet-level model: round-robin from last owner, header, then bytes up to last or MAX_PKT.
   task automatic build_expected();
      logic [8:0] tmp[NUM_REQ][$];
      logic [8:0] b;
      int lo, p, n, c;
      bit found;
      for (int i = 0; i < NUM_REQ; i++) tmp[i] = src_q[i];
      lo = m_last_owner;
      for (int guard = 0; guard < 64; guard++) begin
         found = 1'b0;
         p = 0;
         for (int k = 1; k <= NUM_REQ; k++) begin
            c = (lo + k) % NUM_REQ;
            if (!found && tmp[c].size() > 0) begin
               found = 1'b1;
               p = c;
            end
         end
         if (!found) break;
         exp_grant_q.push_back(p);
         exp_q.push_back({4'hA, 4'(p)});
         n = 0;
         b = '0;
         while (tmp[p].size() > 0) begin
            b = tmp[p].pop_front();
            exp_q.push_back(b[7:0]);
            n++;
            if (b[8] || n == MAX_PKT) break;
         end
         if (!b[8]) exp_trunc_total++;
         lo = p;
      end
      m_last_owner = lo;
   endtask

   task automatic step();
      logic [NUM_REQ-1:0] acc;
      logic [8:0] b;
      int o;
      @(negedge clk);
      rst       = rst_drive;
      fifo_full = full_force;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (src_q[i].size() > 0 && !stall_mask[i]) begin
            req_valid[i]       = 1'b1;
            req_data[i*8 +: 8] = src_q[i][0][7:0];
            req_last[i]        = src_q[i][0][8];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[i*8 +: 8] = 8'($urandom);
            req_last[i]        = 1'($urandom);
         end
      end
      #1;
      cyc++;
      saw_wr   = fifo_wr;
      saw_data = fifo_data;
      saw_acc  = 0;
      if (rst_drive) begin
         check("trunc_err", 32'(trunc_err), 32'(trunc_pending));
         if (trunc_err) seen_trunc++;
      end
      trunc_pending = 1'b0;
      if (fifo_wr) begin
         wr_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) check("fifo_wr_extra", 32'(fifo_wr), 32'(0));
         else check("fifo_data", 32'(fifo_data), 32'(exp_q.pop_front()));
      end
      if (grant != '0 && prev_grant == '0) begin
         if (exp_grant_q.size() == 0) begin
            check("grant_extra", 32'(grant), 32'(0));
         end else begin
            o = exp_grant_q.pop_front();
            check("grant_order", 32'(grant), 32'(1) << o);
         end
      end
      prev_grant = grant;
      acc = req_valid & req_ready;
      if (acc != '0) begin
         check("accept_owner", 32'(acc), 32'(grant));
         for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) begin
               b = src_q[i].pop_front();
               pkt_cnt++;
               saw_acc++;
               if (b[8]) begin
                  pkt_cnt = 0;
               end else if (pkt_cnt == MAX_PKT) begin
                  trunc_pending = 1'b1;
                  pkt_cnt = 0;
               end
            end
         end
      end
   endtask

   task automatic run_until_done(input int budget, input string tag);
      int n;
      n = 0;
      while ((pending() || busy) && n < budget) begin
         step();
         n++;
      end
      check({tag, "_done_in_budget"}, 32'(n < budget), 32'(1));
      check({tag, "_exp_left"}, 32'(exp_q.size()), 32'(0));
   endtask

   task automatic wait_for_wr(input logic [7:0] data, input string tag);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!(saw_wr && saw_data == data) && n < 50);
      check({tag, "_seen"}, 32'(saw_wr && saw_data == data), 32'(1));
   endtask

   task automatic do_reset();
      rst_drive  = 1'b0;
      stall_mask = '0;
      full_force = 1'b0;
      exp_q.delete();
      exp_grant_q.delete();
      pkt_cnt       = 0;
      trunc_pending = 1'b0;
      prev_grant    = '0;
      m_last_owner  = NUM_REQ - 1;
      repeat (2) begin
         step();
         check("rst_busy", 32'(busy), 32'(0));
         check("rst_fifo_wr", 32'(fifo_wr), 32'(0));
         check("rst_req_ready", 32'(req_ready), 32'(0));
         check("rst_grant", 32'(grant), 32'(0));
         check("rst_trunc", 32'(trunc_err), 32'(0));
         check("rst_state", 32'(dbg_state), 32'(uart_pkg::ST_IDLE));
      end
      rst_drive = 1'b1;
   endtask

   task automatic push_pkt(input int r, input int len);
      for (int k = 0; k < len; k++) begin
         src_q[r].push_back({1'(k == len - 1), 8'($urandom)});
      end
   endtask

   initial begin
      int p, tb_base, te_base, acc_n, n;
      rst        = 1'b0;
      rst_drive  = 1'b0;
      req_valid  = '0;
      req_data   = '0;
      req_last   = '0;
      fifo_full  = 1'b0;
      full_force = 1'b0;
      stall_mask = '0;

      // Single requester with fixed bytes, valid already during reset.
      src_q[2].push_back(9'h011);
      src_q[2].push_back(9'h022);
      src_q[2].push_back(9'h133);
      do_reset();
      build_expected();
      wr_cyc_q.delete();
      run_until_done(40, "single");
      check("single_wr_count", 32'(wr_cyc_q.size()), 32'(4));
      if (wr_cyc_q.size() == 4) check("single_consecutive", 32'(wr_cyc_q[3] - wr_cyc_q[0]), 32'(3));
      check("single_busy_after", 32'(busy), 32'(0));
      check("single_grant_after", 32'(grant), 32'(0));

      // All requesters continuously valid with 1-byte packets after reset.
      do_reset();
      for (int r = 0; r < NUM_REQ; r++) begin
         push_pkt(r, 1);
         push_pkt(r, 1);
      end
      build_expected();
      wr_cyc_q.delete();
      run_until_done(200, "rr");
      check("rr_wr_count", 32'(wr_cyc_q.size()), 32'(4 * NUM_REQ));
      // Each 1-byte packet takes header + byte + one idle cycle.
      if (wr_cyc_q.size() == 4 * NUM_REQ)
         check("rr_span", 32'(wr_cyc_q[4*NUM_REQ-1] - wr_cyc_q[0]), 32'(3 * 2 * NUM_REQ - 2));

      // Backpressure for 5 cycles mid-packet; packet length equals MAX_PKT with last set.
      push_pkt(3, MAX_PKT);
      tb_base = seen_trunc;
      build_expected();
      wait_for_wr(8'hA3, "bp_hdr");
      step();
      full_force = 1'b1;
      repeat (5) begin
         step();
         check("bp_req_ready", 32'(req_ready), 32'(0));
         check("bp_fifo_wr", 32'(fifo_wr), 32'(0));
      end
      full_force = 1'b0;
      run_until_done(60, "bp");
      check("bp_no_trunc", 32'(seen_trunc - tb_base), 32'(0));

      // Six bytes on requester 1 are cut after MAX_PKT and resume as a new packet.
      push_pkt(1, 6);
      tb_base = seen_trunc;
      te_base = exp_trunc_total;
      build_expected();
      run_until_done(80, "trunc");
      check("trunc_pulses", 32'(seen_trunc - tb_base), 32'(exp_trunc_total - te_base));

      // Owner stalls for 10 cycles while others stay valid.
      push_pkt(0, 2);
      push_pkt(1, 3);
      push_pkt(2, 2);
      build_expected();
      p = exp_grant_q[0];
      wait_for_wr({4'hA, 4'(p)}, "stall_hdr");
      stall_mask = NUM_REQ'(1) << p;
      repeat (10) begin
         step();
         check("stall_fifo_wr", 32'(fifo_wr), 32'(0));
         check("stall_grant", 32'(grant), 32'(1) << p);
      end
      stall_mask = '0;
      run_until_done(120, "stall");

      // Reset after two data bytes of a five-byte stream; requester 0 must win afterwards.
      push_pkt(0, 2);
      push_pkt(1, 2);
      push_pkt(3, 5);
      build_expected();
      p = exp_grant_q[0];
      wait_for_wr({4'hA, 4'(p)}, "rstmid_hdr");
      acc_n = 0;
      n = 0;
      while (acc_n < 2 && n < 20) begin
         step();
         acc_n += saw_acc;
         n++;
      end
      check("rstmid_two_bytes", 32'(acc_n), 32'(2));
      do_reset();
      build_expected();
      run_until_done(120, "rstmid");
      check("final_busy", 32'(busy), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
